// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings shared by the master and the register slaves
package ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [1:0] HRESP_OKAY      = 2'b00;
  localparam logic [1:0] HRESP_ERROR     = 2'b01;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
endpackage

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: pipelined single-transfer AHB-Lite initiator fed by a valid/ready command stream
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 16
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                busy,
  output logic [ADDR_W-1:0]   haddr,
  output logic [1:0]          htrans,
  output logic                hwrite,
  output logic [2:0]          hsize,
  output logic [2:0]          hburst,
  output logic [3:0]          hprot,
  output logic [DATA_W-1:0]   hwdata,
  input  logic [DATA_W-1:0]   hrdata,
  input  logic                hready,
  input  logic [1:0]          hresp
);
  logic              a_valid, a_write, d_valid, d_write;
  logic [DATA_W-1:0] a_wdata;
  logic              accept, rsp_fire, err_resp;
  assign cmd_ready = !a_valid || hready;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_fire  = d_valid && hready;
  assign err_resp  = hresp != HRESP_OKAY;
  assign busy      = a_valid || d_valid;
  assign htrans    = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite    = a_write;
  assign hsize     = HSIZE_WORD;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_DATA_PRIV;
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      a_valid   <= 1'b0;
      a_write   <= 1'b0;
      a_wdata   <= '0;
      haddr     <= '0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      hwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      err_count <= '0;
    end else begin
      // A empty accepts regardless of hready; a full A only turns over on hready
      a_valid <= accept || (a_valid && !hready);
      if (accept) begin
        haddr   <= cmd_addr;
        a_write <= cmd_write;
        a_wdata <= cmd_wdata;
      end
      if (hready) begin
        d_valid <= a_valid;
        d_write <= a_write;
        if (a_valid && a_write) hwdata <= a_wdata;
      end
      rsp_valid <= rsp_fire;
      rsp_err   <= rsp_fire && err_resp;
      rsp_rdata <= (rsp_fire && !d_write && !err_resp) ? hrdata : '0;
      if (rsp_fire && err_resp && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed checks of the AHB-Lite master against a two-register slave model
module tb_ahb_lite_master;
  logic        hclk, hreset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, busy, hwrite, hready;
  logic [31:0] rsp_rdata, haddr, hwdata, hrdata;
  logic [15:0] err_count;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [31:0] reg0, reg1, dp_addr;
  logic        dp_valid, dp_write;
  int          errors = 0;
  int          checks = 0;

  ahb_lite_master dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_count(err_count), .busy(busy),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // slave: reg0 at 0x8000_0000 (max_sequence_x), reg1 at 0x8000_0004
  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      reg0 <= 32'h0000_00AB;
      reg1 <= 32'h0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr <= 32'h0;
    end else if (hready) begin
      if (dp_valid && dp_write) begin
        if (dp_addr[2]) reg1 <= hwdata;
        else reg0 <= hwdata;
      end
      dp_valid <= htrans == 2'b10;
      dp_write <= hwrite;
      dp_addr  <= haddr;
    end
  end
  assign hrdata = dp_addr[2] ? reg1 : reg0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  logic [31:0] b_addr [4];
  logic [31:0] b_data [4];
  logic        b_wr   [4];
  logic [31:0] b_rsp  [4];

  initial begin
    hreset = 1'b1;
    hready = 1'b1;
    hresp  = 2'b00;
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge hclk);
    @(negedge hclk);
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwrite", 32'(hwrite), 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_consts", {21'h0, hsize, hburst, hprot, 1'b0}, {21'h0, 3'b010, 3'b000, 4'b0011, 1'b0});
    hreset = 1'b0;

    // single write
    @(negedge hclk);
    set_cmd(1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678);
    #1 chk("wr_cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge hclk);
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    chk("wr_htrans", 32'(htrans), 32'h2);
    chk("wr_haddr", haddr, 32'h8000_0004);
    chk("wr_hwrite", 32'(hwrite), 32'h1);
    chk("wr_busy", 32'(busy), 32'h1);
    @(negedge hclk);
    chk("wr_htrans_idle", 32'(htrans), 32'h0);
    chk("wr_hwdata", hwdata, 32'h1234_5678);
    chk("wr_no_rsp_yet", 32'(rsp_valid), 32'h0);
    @(negedge hclk);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_err", 32'(rsp_err), 32'h0);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge hclk);
    chk("wr_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("wr_idle_busy", 32'(busy), 32'h0);
    chk("wr_slave_reg1", reg1, 32'h1234_5678);

    // single read
    set_cmd(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    @(negedge hclk);
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd_hwrite", 32'(hwrite), 32'h0);
    @(negedge hclk);
    @(negedge hclk);
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h0000_00AB);
    chk("rd_rsp_err", 32'(rsp_err), 32'h0);

    // back-to-back: W, R, R, W with cmd_valid held
    b_addr = '{32'h8000_0004, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004};
    b_data = '{32'hCAFE_0001, 32'h0, 32'h0, 32'hBEEF_0002};
    b_wr   = '{1'b1, 1'b0, 1'b0, 1'b1};
    b_rsp  = '{32'h0, 32'h0000_00AB, 32'hCAFE_0001, 32'h0};
    for (int k = 1; k <= 7; k++) begin
      if (k <= 4) begin
        set_cmd(1'b1, b_wr[k-1], b_addr[k-1], b_data[k-1]);
        #1 chk($sformatf("b2b_cmd_ready%0d", k), 32'(cmd_ready), 32'h1);
      end else set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge hclk);
      chk($sformatf("b2b_htrans%0d", k), 32'(htrans), k <= 4 ? 32'h2 : 32'h0);
      if (k <= 4) chk($sformatf("b2b_haddr%0d", k), haddr, b_addr[k-1]);
      chk($sformatf("b2b_rsp_valid%0d", k), 32'(rsp_valid), (k >= 3 && k <= 6) ? 32'h1 : 32'h0);
      if (k >= 3 && k <= 6) chk($sformatf("b2b_rsp_rdata%0d", k), rsp_rdata, b_rsp[k-3]);
    end

    // wait states on a read data phase with a second read waiting in A
    set_cmd(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    @(negedge hclk);
    set_cmd(1'b1, 1'b0, 32'h8000_0004, 32'h0);
    @(negedge hclk);
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    hready = 1'b0;
    #1 chk("ws_cmd_ready", 32'(cmd_ready), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge hclk);
      chk($sformatf("ws_haddr%0d", k), haddr, 32'h8000_0004);
      chk($sformatf("ws_htrans%0d", k), 32'(htrans), 32'h2);
      chk($sformatf("ws_hwrite%0d", k), 32'(hwrite), 32'h0);
      chk($sformatf("ws_hwdata%0d", k), hwdata, 32'hBEEF_0002);
      chk($sformatf("ws_no_rsp%0d", k), 32'(rsp_valid), 32'h0);
    end
    hready = 1'b1;
    @(negedge hclk);
    chk("ws_rsp1_valid", 32'(rsp_valid), 32'h1);
    chk("ws_rsp1_rdata", rsp_rdata, 32'h0000_00AB);
    chk("ws_htrans_idle", 32'(htrans), 32'h0);
    @(negedge hclk);
    chk("ws_rsp2_valid", 32'(rsp_valid), 32'h1);
    chk("ws_rsp2_rdata", rsp_rdata, 32'hBEEF_0002);

    // two-cycle ERROR on read 0x8000_0010, queued read still completes
    @(negedge hclk);
    set_cmd(1'b1, 1'b0, 32'h8000_0010, 32'h0);
    @(negedge hclk);
    set_cmd(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    @(negedge hclk);
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    hready = 1'b0;
    hresp  = 2'b01;
    @(negedge hclk);
    chk("err_first_no_rsp", 32'(rsp_valid), 32'h0);
    chk("err_pending_addr", haddr, 32'h8000_0000);
    hready = 1'b1;
    @(negedge hclk);
    hresp = 2'b00;
    chk("err_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("err_rsp_err", 32'(rsp_err), 32'h1);
    chk("err_rsp_rdata", rsp_rdata, 32'h0);
    chk("err_count1", 32'(err_count), 32'h1);
    @(negedge hclk);
    chk("err_next_valid", 32'(rsp_valid), 32'h1);
    chk("err_next_ok", 32'(rsp_err), 32'h0);
    chk("err_next_rdata", rsp_rdata, 32'h0000_00AB);
    chk("err_count_hold", 32'(err_count), 32'h1);

    // reset while the data phase is stalled
    @(negedge hclk);
    set_cmd(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    @(negedge hclk);
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge hclk);
    hready = 1'b0;
    @(negedge hclk);
    chk("rst2_busy_before", 32'(busy), 32'h1);
    hreset = 1'b1;
    #1;
    chk("rst2_htrans", 32'(htrans), 32'h0);
    chk("rst2_busy", 32'(busy), 32'h0);
    chk("rst2_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst2_err_count", 32'(err_count), 32'h0);
    hready = 1'b1;
    @(negedge hclk);
    chk("rst2_no_rsp", 32'(rsp_valid), 32'h0);
    hreset = 1'b0;
    @(negedge hclk);
    chk("rst2_no_late_rsp", 32'(rsp_valid), 32'h0);
    set_cmd(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    @(negedge hclk);
    set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge hclk);
    @(negedge hclk);
    chk("post_rst_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_rdata", rsp_rdata, 32'h0000_00AB);
    chk("post_rst_err", 32'(rsp_err), 32'h0);
    chk("post_rst_err_count", 32'(err_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
